// File: rtl/qs_pkg.sv
// Shared types and constants for the queue sequencing controller.
package qs_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ENQ,
    DEQ,
    RDWAIT
  } qs_state_t;

endpackage

// File: rtl/queue_sched_if.sv
// Deserializer, storage and status signals of the queue controller in one bundle.
interface queue_sched_if
  import qs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = $clog2(DEPTH + 1)
) ();

  logic              des_valid;
  logic [WORD_W-1:0] des_word;
  logic              des_ack;
  logic              dequeue_in;
  logic              q_wr_en;
  logic [WORD_W-1:0] q_wr_data;
  logic              q_rd_en;
  logic [WORD_W-1:0] q_rd_data;
  logic              status_out;
  logic [LEN_W-1:0]  len_out;
  logic [WORD_W-1:0] data_out;
  logic              underflow;

  // The controller drives the storage, so it takes the master side.
  modport master (
    input  des_valid, des_word, dequeue_in, q_rd_data,
    output des_ack, q_wr_en, q_wr_data, q_rd_en,
    output status_out, len_out, data_out, underflow
  );

  modport slave (
    output des_valid, des_word, dequeue_in, q_rd_data,
    input  des_ack, q_wr_en, q_wr_data, q_rd_en,
    input  status_out, len_out, data_out, underflow
  );

endinterface

// File: rtl/qs_edge_det.sv
// Rising-edge detector: registers a level and emits a one-cycle pulse on 0->1.
module qs_edge_det (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_level,
  output logic o_rise
);

  logic r_levelQ;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_levelQ <= 1'b0;
    end else begin
      r_levelQ <= i_level;
    end
  end

  assign o_rise = i_level & ~r_levelQ;

endmodule

// File: rtl/queue_sched.sv
// Queue sequencing controller: moves deserializer words into storage, turns
// dequeue presses into single reads, and tracks occupancy.
module queue_sched
  import qs_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic clock_1MHz,
  input  logic rst,
  queue_sched_if.master bus
);

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

  qs_state_t         r_state;
  qs_state_t         w_nextState;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_nextLen;
  logic              r_pend;
  logic              w_rise;
  logic              w_enqOk;
  logic              w_underflow;
  logic              w_deqStart;
  logic              r_desAck;
  logic              r_qWrEn;
  logic              r_qRdEn;
  logic              r_status;
  logic              r_underflow;
  logic [WORD_W-1:0] r_qWrData;
  logic [WORD_W-1:0] r_dataOut;

  qs_edge_det u_deqEdge (
    .i_clk   (clock_1MHz),
    .i_rstN  (rst),
    .i_level (bus.dequeue_in),
    .o_rise  (w_rise)
  );

  assign w_enqOk    = bus.des_valid && (r_len < FULL_LEN);
  assign w_deqStart = (r_state == IDLE) && (w_nextState == DEQ);

  // Enqueue wins over a pending press; the press stays pending until served.
  always_comb begin
    w_nextState = r_state;
    w_nextLen   = r_len;
    w_underflow = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enqOk) begin
          w_nextState = ENQ;
        end else if (r_pend && (r_len != '0)) begin
          w_nextState = DEQ;
        end else if (r_pend) begin
          w_underflow = 1'b1;
        end
      end
      ENQ: begin
        w_nextState = IDLE;
        w_nextLen   = r_len + LEN_W'(1);
      end
      DEQ: begin
        w_nextState = RDWAIT;
      end
      RDWAIT: begin
        w_nextState = IDLE;
        w_nextLen   = r_len - LEN_W'(1);
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // A fresh rise re-arms pend even in the cycle it would otherwise clear.
  always_ff @(posedge clock_1MHz) begin
    if (!rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_len   <= w_nextLen;
      r_pend  <= w_rise | (r_pend & ~w_deqStart & ~w_underflow);
    end
  end

  always_ff @(posedge clock_1MHz) begin
    if (!rst) begin
      r_desAck    <= 1'b0;
      r_qWrEn     <= 1'b0;
      r_qWrData   <= '0;
      r_qRdEn     <= 1'b0;
      r_status    <= 1'b0;
      r_underflow <= 1'b0;
      r_dataOut   <= '0;
    end else begin
      r_desAck    <= (w_nextState == ENQ);
      r_qWrEn     <= (w_nextState == ENQ);
      r_qRdEn     <= (w_nextState == DEQ);
      r_status    <= (w_nextState == IDLE) && (w_nextLen < FULL_LEN);
      r_underflow <= w_underflow;
      if (w_nextState == ENQ) begin
        r_qWrData <= bus.des_word;
      end
      if (r_state == RDWAIT) begin
        r_dataOut <= bus.q_rd_data;
      end
    end
  end

  assign bus.des_ack    = r_desAck;
  assign bus.q_wr_en    = r_qWrEn;
  assign bus.q_wr_data  = r_qWrData;
  assign bus.q_rd_en    = r_qRdEn;
  assign bus.status_out = r_status;
  assign bus.len_out    = r_len;
  assign bus.data_out   = r_dataOut;
  assign bus.underflow  = r_underflow;

endmodule

// File: tb/tb_queue_sched.sv
// Directed bench for queue_sched with a small FIFO storage model behind it.
module tb_queue_sched;
  import qs_pkg::*;

  localparam int DEPTH = 8;

  logic clock_1MHz = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int rdPulses = 0;
  int ackPulses = 0;
  int ufPulses = 0;
  int snapRd;
  int snapAck;
  int snapUf;
  logic [7:0] mem [8];
  logic [2:0] wrPtr;
  logic [2:0] rdPtr;

  queue_sched_if #(.DEPTH(DEPTH)) bus ();

  queue_sched #(.DEPTH(DEPTH)) dut (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .bus        (bus)
  );

  always #500 clock_1MHz = ~clock_1MHz;

  // Storage model: write on strobe, read data returned one cycle after q_rd_en.
  always @(posedge clock_1MHz) begin
    if (!rst) begin
      wrPtr         <= 3'd0;
      rdPtr         <= 3'd0;
      bus.q_rd_data <= 8'h00;
    end else begin
      if (bus.q_wr_en) begin
        mem[wrPtr] <= bus.q_wr_data;
        wrPtr      <= wrPtr + 3'd1;
      end
      if (bus.q_rd_en) begin
        bus.q_rd_data <= mem[rdPtr];
        rdPtr         <= rdPtr + 3'd1;
      end
    end
  end

  // Pulse counters sampled mid-cycle.
  always @(negedge clock_1MHz) begin
    if (rst) begin
      if (bus.q_rd_en)   rdPulses++;
      if (bus.des_ack)   ackPulses++;
      if (bus.underflow) ufPulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_1MHz);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] word, input logic deq);
    bus.des_valid  = valid;
    bus.des_word   = word;
    bus.dequeue_in = deq;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one word, wait (bounded) for its ack, then drop valid and return to IDLE.
  task automatic enqWord(input logic [7:0] word);
    applyStimulus(1'b1, word, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.des_ack) break;
    end
    checkOutput("enqAck", 16'(bus.des_ack), 16'd1);
    applyStimulus(1'b0, word, 1'b0);
    tick(1);
  endtask

  task automatic deqPress();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick(1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick(5);
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset held for three cycles.
    rst = 1'b0;
    tick(3);
    checkOutput("rstStatus", 16'(bus.status_out), 16'd0);
    checkOutput("rstLen", 16'(bus.len_out), 16'd0);
    checkOutput("rstData", 16'(bus.data_out), 16'd0);
    checkOutput("rstWrEn", 16'(bus.q_wr_en), 16'd0);
    checkOutput("rstAck", 16'(bus.des_ack), 16'd0);
    checkOutput("rstRdEn", 16'(bus.q_rd_en), 16'd0);
    checkOutput("rstUf", 16'(bus.underflow), 16'd0);
    rst = 1'b1;
    tick(1);
    checkOutput("relStatus", 16'(bus.status_out), 16'd1);
    checkOutput("relLen", 16'(bus.len_out), 16'd0);

    // Single enqueue.
    applyStimulus(1'b1, 8'h80, 1'b0);
    tick(1);
    checkOutput("enqWrEn", 16'(bus.q_wr_en), 16'd1);
    checkOutput("enqWrData", 16'(bus.q_wr_data), 16'h80);
    checkOutput("enqAck1", 16'(bus.des_ack), 16'd1);
    checkOutput("enqStatusBusy", 16'(bus.status_out), 16'd0);
    applyStimulus(1'b0, 8'h80, 1'b0);
    tick(1);
    checkOutput("enqLen", 16'(bus.len_out), 16'd1);
    checkOutput("enqWrEnLow", 16'(bus.q_wr_en), 16'd0);
    checkOutput("enqStatusIdle", 16'(bus.status_out), 16'd1);

    // Fill to capacity, then a ninth word must wait.
    for (int w = 8'h81; w <= 8'h87; w++) enqWord(8'(w));
    checkOutput("fullLen", 16'(bus.len_out), 16'd8);
    checkOutput("fullStatus", 16'(bus.status_out), 16'd0);
    snapAck = ackPulses;
    applyStimulus(1'b1, 8'h88, 1'b0);
    tick(20);
    checkOutput("fullNoAck", 16'(ackPulses - snapAck), 16'd0);
    checkOutput("fullLenHeld", 16'(bus.len_out), 16'd8);
    snapRd = rdPulses;
    applyStimulus(1'b1, 8'h88, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.des_ack) break;
    end
    checkOutput("fullResumeAck", 16'(bus.des_ack), 16'd1);
    applyStimulus(1'b0, 8'h88, 1'b0);
    tick(1);
    checkOutput("fullResumeLen", 16'(bus.len_out), 16'd8);
    checkOutput("fullResumeData", 16'(bus.data_out), 16'h80);
    checkOutput("fullResumeReads", 16'(rdPulses - snapRd), 16'd1);

    // Fresh queue of four words, then a long held press.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    for (int w = 8'h80; w <= 8'h83; w++) enqWord(8'(w));
    checkOutput("heldPreLen", 16'(bus.len_out), 16'd4);
    snapRd = rdPulses;
    snapUf = ufPulses;
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick(200);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick(3);
    checkOutput("heldReads", 16'(rdPulses - snapRd), 16'd1);
    checkOutput("heldData", 16'(bus.data_out), 16'h80);
    checkOutput("heldLen", 16'(bus.len_out), 16'd3);
    checkOutput("heldNoUf", 16'(ufPulses - snapUf), 16'd0);
    repeat (3) deqPress();
    checkOutput("drainData", 16'(bus.data_out), 16'h83);
    checkOutput("drainLen", 16'(bus.len_out), 16'd0);

    // Press on an empty queue.
    snapRd = rdPulses;
    snapUf = ufPulses;
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick(2);
    checkOutput("ufPulseHigh", 16'(bus.underflow), 16'd1);
    tick(1);
    checkOutput("ufPulseLow", 16'(bus.underflow), 16'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick(2);
    checkOutput("ufCount", 16'(ufPulses - snapUf), 16'd1);
    checkOutput("ufNoRead", 16'(rdPulses - snapRd), 16'd0);
    checkOutput("ufData", 16'(bus.data_out), 16'h83);
    checkOutput("ufLen", 16'(bus.len_out), 16'd0);

    // Enqueue and press in the same cycle with two words stored.
    enqWord(8'h90);
    enqWord(8'h91);
    applyStimulus(1'b1, 8'h92, 1'b1);
    tick(1);
    checkOutput("colWrEn", 16'(bus.q_wr_en), 16'd1);
    checkOutput("colWrData", 16'(bus.q_wr_data), 16'h92);
    checkOutput("colRdEnEarly", 16'(bus.q_rd_en), 16'd0);
    applyStimulus(1'b0, 8'h92, 1'b1);
    tick(1);
    checkOutput("colMidLen", 16'(bus.len_out), 16'd3);
    checkOutput("colRdEnWait", 16'(bus.q_rd_en), 16'd0);
    tick(1);
    checkOutput("colRdEn", 16'(bus.q_rd_en), 16'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick(2);
    checkOutput("colLen", 16'(bus.len_out), 16'd2);
    checkOutput("colData", 16'(bus.data_out), 16'h90);

    // Reset while a read is in flight.
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("rdwRstLen", 16'(bus.len_out), 16'd0);
    checkOutput("rdwRstData", 16'(bus.data_out), 16'd0);
    checkOutput("rdwRstStatus", 16'(bus.status_out), 16'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    tick(1);
    checkOutput("rdwRelStatus", 16'(bus.status_out), 16'd1);
    checkOutput("rdwRelLen", 16'(bus.len_out), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
